// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache-to-memory write-back path: FSM states
// and line geometry.
package mem_if_pkg;

  typedef enum logic [1:0] {IDLE, MEM_READ, MEM_WRITE} wb_state_t;

  localparam int LINE_BYTES = 16;
  localparam int LINE_OFF   = $clog2(LINE_BYTES);

endpackage

// File: rtl/dmem_wb_fifo.sv
// Circular store of buffered lines with per-entry valid bits and a parallel
// line-address match giving the youngest hit and the coalesce target.
module dmem_wb_fifo #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 28,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TAG_W-1:0]  lookup_tag,
  input  logic              excl_head,
  input  logic              wr_en,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              pop_en,
  output logic              hit,
  output logic [LINE_W-1:0] hit_data,
  output logic              coal_hit,
  output logic              full,
  output logic              empty,
  output logic [TAG_W-1:0]  head_tag,
  output logic [LINE_W-1:0] head_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [TAG_W-1:0]  tag_reg  [DEPTH];
  logic [LINE_W-1:0] data_reg [DEPTH];
  logic [DEPTH-1:0]  valid_reg;
  logic [PTR_W-1:0]  head_reg, tail_reg;
  logic [PTR_W:0]    count_reg;

  logic [DEPTH-1:0]  match, coal_match;
  logic [PTR_W-1:0]  hit_idx, coal_idx;
  logic              alloc;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi]      = valid_reg[gi] && (tag_reg[gi] == lookup_tag);
      assign coal_match[gi] = match[gi] && !(excl_head && (PTR_W'(gi) == head_reg));
    end
  endgenerate

  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit_idx  = head_reg;
    coal_idx = head_reg;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[head_reg + PTR_W'(k)])      hit_idx  = head_reg + PTR_W'(k);
      if (coal_match[head_reg + PTR_W'(k)]) coal_idx = head_reg + PTR_W'(k);
    end
  end

  assign hit      = |match;
  assign coal_hit = |coal_match;
  assign full     = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign alloc    = wr_en && !coal_hit;
  assign hit_data = data_reg[hit_idx];
  assign head_tag = tag_reg[head_reg];
  // A write merging into the head as its drain starts must reach memory.
  assign head_data = (wr_en && coal_hit && (coal_idx == head_reg)) ? wr_data : data_reg[head_reg];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (pop_en) begin
        valid_reg[head_reg] <= 1'b0;
        head_reg            <= head_reg + 1'b1;
      end
      if (alloc) begin
        valid_reg[tail_reg] <= 1'b1;
        tail_reg            <= tail_reg + 1'b1;
      end
      count_reg <= count_reg + (PTR_W+1)'(alloc) - (PTR_W+1)'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      tag_reg[tail_reg]  <= lookup_tag;
      data_reg[tail_reg] <= wr_data;
    end else if (wr_en) begin
      data_reg[coal_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/dmem_wb_buffer.sv
// Write-back buffer between the data cache and the memory dmem port: read
// priority, forwarding from buffered lines, write merging and background drain.
module dmem_wb_buffer
  import mem_if_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_req_valid,
  input  logic              in_req_we,
  input  logic [ADDR_W-1:0] in_req_addr,
  input  logic [LINE_W-1:0] in_req_data,
  output logic              out_req_ready,
  output logic              out_resp_valid,
  output logic [LINE_W-1:0] out_resp_data,
  output logic              out_dmem_read_en,
  output logic              out_dmem_write_en,
  output logic [ADDR_W-1:0] out_dmem_addr,
  output logic [LINE_W-1:0] out_dmem_write_data,
  input  logic [LINE_W-1:0] in_dmem_read_data,
  input  logic              in_dmem_ready
);

  localparam int TAG_W = ADDR_W - LINE_OFF;

  wb_state_t         state_reg, state_next;
  logic              resp_valid_reg;
  logic [LINE_W-1:0] resp_data_reg;
  logic [ADDR_W-1:0] dmem_addr_reg;
  logic [LINE_W-1:0] dmem_wdata_reg;

  logic [TAG_W-1:0]  req_tag, head_tag;
  logic [LINE_W-1:0] hit_data, head_data;
  logic              hit, coal_hit, full, empty;
  logic              rd_ready, wr_ready, rd_fire, wr_fire, drain_start, pop;
  logic              unused_addr_bits;

  assign req_tag          = in_req_addr[ADDR_W-1:LINE_OFF];
  assign unused_addr_bits = ^in_req_addr[LINE_OFF-1:0];

  assign rd_ready      = (state_reg == IDLE) && !resp_valid_reg;
  assign wr_ready      = !full || coal_hit;
  assign out_req_ready = !reset && (in_req_we ? wr_ready : rd_ready);
  assign rd_fire       = in_req_valid && !in_req_we && out_req_ready;
  assign wr_fire       = in_req_valid && in_req_we && out_req_ready;
  assign drain_start   = (state_reg == IDLE) && !rd_fire && !empty;
  assign pop           = (state_reg == MEM_WRITE) && in_dmem_ready;

  dmem_wb_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .LINE_W(LINE_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .lookup_tag(req_tag),
    .excl_head (state_reg == MEM_WRITE),
    .wr_en     (wr_fire),
    .wr_data   (in_req_data),
    .pop_en    (pop),
    .hit       (hit),
    .hit_data  (hit_data),
    .coal_hit  (coal_hit),
    .full      (full),
    .empty     (empty),
    .head_tag  (head_tag),
    .head_data (head_data)
  );

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (rd_fire && !hit)  state_next = MEM_READ;
        else if (drain_start) state_next = MEM_WRITE;
      end
      MEM_READ:  if (in_dmem_ready) state_next = IDLE;
      MEM_WRITE: if (in_dmem_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
      dmem_addr_reg  <= '0;
      dmem_wdata_reg <= '0;
    end else begin
      state_reg      <= state_next;
      resp_valid_reg <= 1'b0;
      if (rd_fire && hit) begin
        resp_valid_reg <= 1'b1;
        resp_data_reg  <= hit_data;
      end
      if ((state_reg == MEM_READ) && in_dmem_ready) begin
        resp_valid_reg <= 1'b1;
        resp_data_reg  <= in_dmem_read_data;
      end
      // Address and data are held for the whole memory access.
      if (rd_fire && !hit) begin
        dmem_addr_reg <= {req_tag, {LINE_OFF{1'b0}}};
      end else if (drain_start) begin
        dmem_addr_reg  <= {head_tag, {LINE_OFF{1'b0}}};
        dmem_wdata_reg <= head_data;
      end
    end
  end

  assign out_resp_valid      = resp_valid_reg;
  assign out_resp_data       = resp_data_reg;
  assign out_dmem_read_en    = (state_reg == MEM_READ) && !in_dmem_ready;
  assign out_dmem_write_en   = (state_reg == MEM_WRITE) && !in_dmem_ready;
  assign out_dmem_addr       = dmem_addr_reg;
  assign out_dmem_write_data = dmem_wdata_reg;

endmodule

// File: tb/tb_dmem_wb_buffer.sv
// Bench for dmem_wb_buffer: memory model with fixed latency, a line-level
// shadow of the latest written data, and a queue-based response scoreboard.
module tb_dmem_wb_buffer;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 128;
  localparam int MEM_LAT = 10;

  typedef logic [LINE_W-1:0] line_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_req_valid, in_req_we;
  logic [ADDR_W-1:0] in_req_addr;
  line_t             in_req_data;
  logic              out_req_ready, out_resp_valid;
  line_t             out_resp_data;
  logic              out_dmem_read_en, out_dmem_write_en;
  logic [ADDR_W-1:0] out_dmem_addr;
  line_t             out_dmem_write_data, in_dmem_read_data;
  logic              in_dmem_ready;

  always #5 clk = ~clk;

  dmem_wb_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk                (clk),
    .reset              (reset),
    .in_req_valid       (in_req_valid),
    .in_req_we          (in_req_we),
    .in_req_addr        (in_req_addr),
    .in_req_data        (in_req_data),
    .out_req_ready      (out_req_ready),
    .out_resp_valid     (out_resp_valid),
    .out_resp_data      (out_resp_data),
    .out_dmem_read_en   (out_dmem_read_en),
    .out_dmem_write_en  (out_dmem_write_en),
    .out_dmem_addr      (out_dmem_addr),
    .out_dmem_write_data(out_dmem_write_data),
    .in_dmem_read_data  (in_dmem_read_data),
    .in_dmem_ready      (in_dmem_ready)
  );

  int checks = 0, failures = 0, cyc = 0;
  int rd_acc = 0, wr_acc = 0;
  int last_resp_cyc = -1, last_ready_cyc = -1, last_accept_cyc = -1;
  line_t       mem    [int unsigned];
  line_t       shadow [int unsigned];
  line_t       exp_q  [$];
  int unsigned wlog_addr [$];
  line_t       wlog_data [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input line_t act, input line_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic line_t init_line(input int unsigned ln);
    return {ln ^ 32'hA5A5_0000, ~ln, ln * 32'h9E37_79B1, ln + 32'h1234_5678};
  endfunction

  function automatic line_t rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Memory: accepts an enable, completes MEM_LAT cycles later with a 1-cycle ready.
  initial begin : mem_model
    bit busy, is_wr;
    int lat;
    int unsigned a;
    line_t d;
    busy = 0; is_wr = 0; lat = 0; a = 0; d = '0;
    in_dmem_ready = 1'b0;
    in_dmem_read_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 0;
        in_dmem_ready = 1'b0;
        continue;
      end
      if (in_dmem_ready) in_dmem_ready = 1'b0;
      if (busy) begin
        check("dmem_addr_stable", out_dmem_addr, a);
        if (is_wr) check("dmem_wdata_stable", out_dmem_write_data, d);
        lat--;
        if (lat == 0) begin
          busy = 0;
          if (is_wr) begin
            mem[a >> 4] = d;
            wlog_addr.push_back(a);
            wlog_data.push_back(d);
          end else begin
            in_dmem_read_data = mem.exists(a >> 4) ? mem[a >> 4] : init_line(a >> 4);
          end
          in_dmem_ready = 1'b1;
          last_ready_cyc = cyc;
          #1;
          check("en_low_in_ready", {out_dmem_read_en, out_dmem_write_en}, 0);
        end
      end else if (out_dmem_read_en || out_dmem_write_en) begin
        check("single_enable", out_dmem_read_en & out_dmem_write_en, 0);
        busy  = 1;
        is_wr = out_dmem_write_en;
        a     = out_dmem_addr;
        d     = out_dmem_write_data;
        lat   = MEM_LAT;
        if (is_wr) wr_acc++; else rd_acc++;
        check("dmem_addr_aligned", a[3:0], 0);
      end
    end
  end

  // Response monitor: every response pulse consumes one expected line.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset && out_resp_valid) begin
        last_resp_cyc = cyc;
        if (exp_q.size() == 0) check("resp_unexpected", 1, 0);
        else check("resp_data", out_resp_data, exp_q.pop_front());
      end
    end
  end

  // Called at a falling edge; returns at a falling edge with valid dropped.
  task automatic issue(input bit we, input logic [ADDR_W-1:0] addr, input line_t data);
    int unsigned ln;
    int waited;
    ln = addr >> 4;
    waited = 0;
    in_req_valid = 1'b1; in_req_we = we; in_req_addr = addr; in_req_data = data;
    #1;
    while (!out_req_ready) begin
      waited++;
      if (waited > 300) begin
        check("req_accept_timeout", 0, 1);
        in_req_valid = 1'b0;
        return;
      end
      @(negedge clk); #1;
    end
    last_accept_cyc = cyc;
    if (we) shadow[ln] = data;
    else exp_q.push_back(shadow.exists(ln) ? shadow[ln] : init_line(ln));
    @(negedge clk);
    in_req_valid = 1'b0;
    $display("req %s addr=%h accepted at cycle %0d", we ? "WR" : "RD", addr, last_accept_cyc);
  endtask

  task automatic wait_quiet();
    int quiet, n;
    quiet = 0; n = 0;
    while (quiet < 20) begin
      @(negedge clk);
      n++;
      if (out_dmem_read_en || out_dmem_write_en || in_dmem_ready || out_resp_valid) quiet = 0;
      else quiet++;
      if (n > 3000) begin
        check("quiet_timeout", 0, 1);
        return;
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int w0, r0, n0, seen;
    line_t d1, d2, d3, d4, dx;
    line_t fill_d [5];
    int unsigned ln;
    logic [ADDR_W-1:0] ra;

    in_req_valid = 1'b0; in_req_we = 1'b1; in_req_addr = '0; in_req_data = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready_wr", out_req_ready, 0);
    in_req_we = 1'b0; #1;
    check("rst_req_ready_rd", out_req_ready, 0);
    check("rst_resp_valid", out_resp_valid, 0);
    check("rst_resp_data", out_resp_data, 0);
    check("rst_read_en", out_dmem_read_en, 0);
    check("rst_write_en", out_dmem_write_en, 0);
    check("rst_dmem_addr", out_dmem_addr, 0);
    check("rst_dmem_wdata", out_dmem_write_data, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single buffered write drains to memory once idle.
    d1 = rand_line(); w0 = wr_acc; n0 = wlog_addr.size();
    issue(1, 32'h100, d1);
    wait_quiet();
    check("drain_access_count", wr_acc - w0, 1);
    check("drain_addr", wlog_addr[n0], 32'h100);
    check("drain_data", wlog_data[n0], d1);

    // Read forwarded from a buffered line, no memory read.
    d2 = rand_line(); r0 = rd_acc;
    issue(1, 32'h200, d2);
    issue(0, 32'h204, '0);
    @(negedge clk); #1;
    check("hit_resp_latency", last_resp_cyc, last_accept_cyc + 1);
    wait_quiet();
    check("hit_no_mem_read", rd_acc - r0, 0);

    // Read miss goes to memory; response one cycle after ready.
    r0 = rd_acc;
    issue(0, 32'h300, '0);
    wait_quiet();
    check("miss_read_count", rd_acc - r0, 1);
    check("miss_resp_latency", last_resp_cyc, last_ready_cyc + 1);

    // Five writes: the fifth stalls until the first drain completes.
    n0 = wlog_addr.size();
    for (int i = 0; i < 5; i++) begin
      fill_d[i] = rand_line();
      issue(1, 32'h1000 + 32'(i * 16), fill_d[i]);
    end
    check("full_accept_cycle", last_accept_cyc, last_ready_cyc + 1);
    wait_quiet();
    check("fill_write_count", wlog_addr.size() - n0, 5);
    for (int i = 0; i < 5; i++) begin
      if (n0 + i < wlog_addr.size()) begin
        check("fill_order_addr", wlog_addr[n0 + i], 32'h1000 + 32'(i * 16));
        check("fill_order_data", wlog_data[n0 + i], fill_d[i]);
      end
    end

    // Repeat write to a line not under drain merges in place.
    dx = rand_line(); d3 = rand_line(); d4 = rand_line(); n0 = wlog_addr.size();
    issue(1, 32'h500, dx);
    issue(1, 32'h400, d3);
    issue(1, 32'h400, d4);
    wait_quiet();
    check("coal_write_count", wlog_addr.size() - n0, 2);
    if (wlog_addr.size() - n0 == 2) begin
      check("coal_first_addr", wlog_addr[n0], 32'h500);
      check("coal_addr", wlog_addr[n0 + 1], 32'h400);
      check("coal_data", wlog_data[n0 + 1], d4);
    end

    // Reset in the middle of a drain abandons it and empties the buffer.
    issue(1, 32'h600, rand_line());
    seen = 0;
    for (int i = 0; i < 50 && !out_dmem_write_en; i++) @(negedge clk);
    check("drain_started", out_dmem_write_en, 1);
    reset = 1'b1;
    @(negedge clk); #1;
    check("mid_rst_req_ready", out_req_ready, 0);
    check("mid_rst_resp_valid", out_resp_valid, 0);
    check("mid_rst_write_en", out_dmem_write_en, 0);
    check("mid_rst_read_en", out_dmem_read_en, 0);
    check("mid_rst_dmem_addr", out_dmem_addr, 0);
    check("mid_rst_dmem_wdata", out_dmem_write_data, 0);
    mem.delete(); shadow.delete(); exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    w0 = wr_acc;
    in_req_we = 1'b1; #1;
    check("post_rst_wr_ready", out_req_ready, 1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_dmem_write_en || out_dmem_read_en) seen++;
    end
    check("post_rst_no_enables", seen, 0);
    check("post_rst_no_access", wr_acc - w0, 0);

    // Random traffic over a few lines against the shadow model.
    for (int n = 0; n < 300; n++) begin
      ln = 32'h200 + $urandom_range(0, 5);
      ra = (ln << 4) | 32'($urandom_range(0, 15));
      issue($urandom_range(0, 99) < 55, ra, rand_line());
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_quiet();
    for (int unsigned l = 32'h200; l < 32'h206; l++) begin
      if (shadow.exists(l)) check("final_mem_line", mem.exists(l) ? mem[l] : init_line(l), shadow[l]);
    end
    check("resp_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
